// File: rtl/upsampling.sv
// -----------------------------------------------------------------------------
// upsampling
//
// 2x nearest-neighbour upsampler for a raster stream. Pooled (half-resolution)
// pixels arrive tagged with the full-resolution frame counters. Each pooled
// row is written into one bank of a ping-pong line buffer. The same row is
// read back two full-resolution lines later and replicated over a 2x2 block.
//
// Timing: cycle t forms the bank and address from the counters. Cycle t+1
// holds the memory data. Cycle t+2 presents the output registers. The
// latency is fixed at 2 clocks, and out_vcnt/out_hcnt are delayed to stay
// aligned with out_pixels.
//
// Ports
//   clock       : single clock, all logic on the rising edge
//   n_rst       : synchronous active-low reset (pipeline only, not the buffer)
//   in_enable   : a pooled pixel is valid this cycle
//   in_pixels   : pooled pixel, channel p at [p*FIXED_BITW +: FIXED_BITW]
//   in_vcnt     : full-resolution frame line counter
//   in_hcnt     : full-resolution frame column counter
//   out_enable  : out_pixels is an active image pixel
//   out_pixels  : upsampled pixel (zero when out_enable is low)
//   out_vcnt    : full-resolution line of out_pixels
//   out_hcnt    : full-resolution column of out_pixels
// -----------------------------------------------------------------------------
module upsampling #(
  parameter int WIDTH      = -1,  // active width, full-resolution pixels (even)
  parameter int HEIGHT     = -1,  // active height, full-resolution lines (even)
  parameter int W_WIDTH    = -1,  // frame width including blanking
  parameter int W_HEIGHT   = -1,  // frame height including blanking (>= HEIGHT+2)
  parameter int FIXED_BITW = -1,  // bits per channel value
  parameter int UNITS      = -1,  // channels per pixel
  // The guards keep elaboration well-formed when the -1 defaults are kept.
  localparam int V_BITW    = (W_HEIGHT > 1) ? $clog2(W_HEIGHT) : 1,
  localparam int H_BITW    = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1,
  localparam int PIX_BITW  = (FIXED_BITW > 0 && UNITS > 0) ? FIXED_BITW * UNITS : 1
) (
  input  logic                clock,
  input  logic                n_rst,
  input  logic                in_enable,
  input  logic [PIX_BITW-1:0] in_pixels,
  input  logic [V_BITW-1:0]   in_vcnt,
  input  logic [H_BITW-1:0]   in_hcnt,
  output logic                out_enable,
  output logic [PIX_BITW-1:0] out_pixels,
  output logic [V_BITW-1:0]   out_vcnt,
  output logic [H_BITW-1:0]   out_hcnt
);

  // Entries per bank: one per pooled column of the full frame width.
  localparam int HALF     = (W_WIDTH >= 2) ? W_WIDTH / 2 : 1;
  localparam int A_BITW   = (HALF > 1) ? $clog2(HALF) : 1;
  // Bit 1 of a line number selects the bank. Pooled row y is written on line
  // 2y+1 and read on lines 2y+2 and 2y+3. Those lines always fall in the
  // other half of a 4-line period, so a read and a write in the same cycle
  // never share a bank.
  localparam int BANK_BIT = (V_BITW > 1) ? 1 : 0;

  // Ping-pong line buffer.
  logic [PIX_BITW-1:0] r_bank0 [HALF];
  logic [PIX_BITW-1:0] r_bank1 [HALF];

  // Stage 1: memory data plus the aligned row, column and activity.
  logic [PIX_BITW-1:0] r_s1_data;
  logic [V_BITW-1:0]   r_s1_vcnt;
  logic [H_BITW-1:0]   r_s1_hcnt;
  logic                r_s1_active;

  // Stage 2: output registers.
  logic                r_out_enable;
  logic [PIX_BITW-1:0] r_out_pixels;
  logic [V_BITW-1:0]   r_out_vcnt;
  logic [H_BITW-1:0]   r_out_hcnt;

  logic [V_BITW-1:0]   w_row;       // output row = (in_vcnt - 2) mod W_HEIGHT
  logic [H_BITW-1:0]   w_col_half;  // pooled column = in_hcnt >> 1
  logic [A_BITW-1:0]   w_addr;
  logic                w_addr_ok;
  logic                w_active;

  always_comb begin
    // Lines 0 and 1 wrap to the blanking rows W_HEIGHT-2 and W_HEIGHT-1.
    w_row      = (in_vcnt >= V_BITW'(2)) ? (in_vcnt - V_BITW'(2))
                                         : (in_vcnt + V_BITW'(W_HEIGHT - 2));
    w_col_half = in_hcnt >> 1;
    w_addr     = A_BITW'(w_col_half);
    // Columns beyond the buffer may still appear on the counter. Writes there
    // are dropped, and reads there return zero, so the buffer is never
    // accessed out of range.
    w_addr_ok  = int'(w_col_half) < HALF;
    w_active   = (int'(w_row) < HEIGHT) && (int'(in_hcnt) < WIDTH);
  end

  // NOTE: the line buffer is deliberately not reset. Every entry that can
  // reach an active output is written before it is read, and leaving out
  // the reset keeps the array mappable onto block RAM.
  always_ff @(posedge clock) begin
    if (in_enable && w_addr_ok) begin
      if (in_vcnt[BANK_BIT]) begin
        r_bank1[w_addr] <= in_pixels;
      end else begin
        r_bank0[w_addr] <= in_pixels;
      end
    end
  end

  // NOTE: every register below uses non-blocking assignment. Stage 2
  // therefore samples the value stage 1 held before this edge, which is
  // what gives the fixed two-clock latency.
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      r_s1_data    <= '0;
      r_s1_vcnt    <= '0;
      r_s1_hcnt    <= '0;
      r_s1_active  <= 1'b0;
      r_out_enable <= 1'b0;
      r_out_pixels <= '0;
      r_out_vcnt   <= '0;
      r_out_hcnt   <= '0;
    end else begin
      if (w_addr_ok) begin
        r_s1_data <= w_row[BANK_BIT] ? r_bank1[w_addr] : r_bank0[w_addr];
      end else begin
        r_s1_data <= '0;
      end
      r_s1_vcnt    <= w_row;
      r_s1_hcnt    <= in_hcnt;
      r_s1_active  <= w_active;

      r_out_enable <= r_s1_active;
      // Blanking positions output zero rather than stale buffer contents.
      r_out_pixels <= r_s1_active ? r_s1_data : '0;
      r_out_vcnt   <= r_s1_vcnt;
      r_out_hcnt   <= r_s1_hcnt;
    end
  end

  assign out_enable = r_out_enable;
  assign out_pixels = r_out_pixels;
  assign out_vcnt   = r_out_vcnt;
  assign out_hcnt   = r_out_hcnt;

endmodule

// File: tb/tb_upsampling.sv
// -----------------------------------------------------------------------------
// tb_upsampling
//
// Scoreboard bench for upsampling (8x8 active area in a 10x10 frame, 2 x 8-bit
// channels). The driver walks the full-resolution counters. In each cycle it
// writes a pooled pixel on odd lines and odd columns, and it pushes the
// expected output for that cycle, due two clocks later. A separate monitor
// pops and compares on the falling edge.
//
// Frames:
//   A  clean frame, reference pattern
//   B  reference pattern plus writes at in_hcnt=10 on lines 1 and 3
//   C  offset pattern, one-clock reset pulse at in_vcnt=5, in_hcnt=4
//   D  clean frame, reference pattern again
// -----------------------------------------------------------------------------
module tb_upsampling;

  localparam int WIDTH      = 8;
  localparam int HEIGHT     = 8;
  localparam int W_WIDTH    = 10;
  localparam int W_HEIGHT   = 10;
  localparam int FIXED_BITW = 8;
  localparam int UNITS      = 2;
  localparam int PW         = FIXED_BITW * UNITS;
  localparam int VB         = $clog2(W_HEIGHT);
  localparam int HB         = $clog2(W_WIDTH);

  logic          clock     = 1'b0;
  logic          n_rst     = 1'b0;
  logic          in_enable = 1'b0;
  logic [PW-1:0] in_pixels = '0;
  logic [VB-1:0] in_vcnt   = '0;
  logic [HB-1:0] in_hcnt   = '0;
  logic          out_enable;
  logic [PW-1:0] out_pixels;
  logic [VB-1:0] out_vcnt;
  logic [HB-1:0] out_hcnt;

  upsampling #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .W_WIDTH    (W_WIDTH),
    .W_HEIGHT   (W_HEIGHT),
    .FIXED_BITW (FIXED_BITW),
    .UNITS      (UNITS)
  ) dut (
    .clock      (clock),
    .n_rst      (n_rst),
    .in_enable  (in_enable),
    .in_pixels  (in_pixels),
    .in_vcnt    (in_vcnt),
    .in_hcnt    (in_hcnt),
    .out_enable (out_enable),
    .out_pixels (out_pixels),
    .out_vcnt   (out_vcnt),
    .out_hcnt   (out_hcnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            due;
    logic          en;
    logic [PW-1:0] pix;
    logic [VB-1:0] v;
    logic [HB-1:0] h;
  } exp_t;

  exp_t sb[$];
  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_active  = 0;
  int   seen_active = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Pooled pixel (y,x): {16y+x+off, its bitwise inverse}.
  function automatic logic [PW-1:0] pool_pix(input int y, input int x, input int off);
    logic [7:0] b;
    b = 8'(16 * y + x + off);
    return {b, ~b};
  endfunction

  // Drives one cycle and pushes the output expected two clocks later.
  task automatic drive(input int v, input int h, input bit rst_on,
                       input int off, input bit oob);
    exp_t e;
    int   r;
    bit   wr;
    @(posedge clock);
    #1;
    wr = oob || ((v % 2 == 1) && (h % 2 == 1) &&
                 (v / 2 < HEIGHT / 2) && (h / 2 < WIDTH / 2));
    n_rst     = ~rst_on;
    in_vcnt   = VB'(v);
    in_hcnt   = HB'(h);
    in_enable = wr;
    in_pixels = oob ? 16'hA55A : (wr ? pool_pix(v / 2, h / 2, off) : 16'hFFFF);
    r = (v >= 2) ? v - 2 : v + W_HEIGHT - 2;
    e.due = cyc + 2;
    if (rst_on) begin
      // The reset edge clears both pipeline stages. The output due next
      // cycle and the output due from this cycle both become zero.
      if (sb.size() > 0) begin
        if (sb[sb.size()-1].en) exp_active--;
        sb[sb.size()-1].en  = 1'b0;
        sb[sb.size()-1].pix = '0;
        sb[sb.size()-1].v   = '0;
        sb[sb.size()-1].h   = '0;
      end
      e.en  = 1'b0;
      e.pix = '0;
      e.v   = '0;
      e.h   = '0;
    end else begin
      e.en  = (r < HEIGHT) && (h < WIDTH);
      e.pix = e.en ? pool_pix(r / 2, h / 2, off) : '0;
      e.v   = VB'(r);
      e.h   = HB'(h);
    end
    if (e.en) exp_active++;
    sb.push_back(e);
  endtask

  task automatic run_frame(input int off, input bit oob, input bit rst_pulse);
    for (int v = 0; v < W_HEIGHT; v++) begin
      for (int h = 0; h < W_WIDTH; h++) begin
        drive(v, h, rst_pulse && v == 5 && h == 4, off, 1'b0);
        if (oob && h == W_WIDTH - 1 && (v == 1 || v == 3))
          drive(v, 10, 1'b0, off, 1'b1);
      end
    end
  endtask

  // Monitor: compares every due entry on the falling edge.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin : pop_one
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (e.due != cyc ||
          {out_enable, out_pixels, out_vcnt, out_hcnt} !== {e.en, e.pix, e.v, e.h}) begin
        miscompares++;
        $display("FAIL out[cyc %0d due %0d]: got en=%0b pix=%h v=%0d h=%0d, want en=%0b pix=%h v=%0d h=%0d",
                 cyc, e.due, out_enable, out_pixels, out_vcnt, out_hcnt,
                 e.en, e.pix, e.v, e.h);
      end
      if (out_enable === 1'b1) seen_active++;
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) drive(0, i, 1'b1, 0, 1'b0);
    run_frame(0,     1'b0, 1'b0);  // A
    run_frame(0,     1'b1, 1'b0);  // B
    run_frame(8'h80, 1'b0, 1'b1);  // C
    run_frame(0,     1'b0, 1'b0);  // D

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    @(negedge clock);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end

    vectors++;
    if (seen_active != exp_active) begin
      miscompares++;
      $display("FAIL active_count: got %0d, want %0d", seen_active, exp_active);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
